systolic_pe: RTL and testbench

SYSTOLIC_PE -- requirements
Module: systolic_pe

---
 rtl/systolic_pe_if.sv | 30 +++
 rtl/systolic_pe.sv | 86 ++++++++
 tb/tb_systolic_pe.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pe_if.sv
// Operand/result bundle for one systolic processing element.
// The master drives the west/north inputs; the slave is the PE itself.
interface systolic_pe_if #(
  parameter int DW = 8,
  parameter int K  = 4
);
  localparam int AW = 2*DW + $clog2(K);

  logic          enable;
  logic          in_valid;
  logic          signed_mode;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          out_valid;
  logic [AW-1:0] acc_out;
  logic          done;
  logic          busy;

  modport master (
    output enable, in_valid, signed_mode, a_in, b_in,
    input  a_out, b_out, out_valid, acc_out, done, busy
  );

  modport slave (
    input  enable, in_valid, signed_mode, a_in, b_in,
    output a_out, b_out, out_valid, acc_out, done, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// Systolic PE: forwards operands east/south with one-cycle skew and
// accumulates K products per group into a full-precision dot product.
module systolic_pe #(
  parameter int DW = 8,
  parameter int K  = 4
) (
  input logic          clk,
  input logic          rst,
  systolic_pe_if.slave bus
);
  localparam int AW = 2*DW + $clog2(K);
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q;
  logic                   mode_q;
  logic [AW-1:0]          acc_q;

  logic                   accept;
  logic                   beat_mode;
  logic                   last_beat;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0]        prod_u;
  logic [AW-1:0]          product;
  logic [AW-1:0]          sum;

  // The first beat of a group uses the live mode; later beats use the latched one.
  always_comb begin
    accept    = bus.enable & bus.in_valid;
    beat_mode = (state_q == IDLE) ? bus.signed_mode : mode_q;
    prod_s    = $signed({{DW{bus.a_in[DW-1]}}, bus.a_in}) *
                $signed({{DW{bus.b_in[DW-1]}}, bus.b_in});
    prod_u    = {{DW{1'b0}}, bus.a_in} * {{DW{1'b0}}, bus.b_in};
    product   = beat_mode ? AW'(prod_s) : AW'(prod_u);
    sum       = ((state_q == IDLE) ? '0 : acc_q) + product;
    last_beat = (state_q == IDLE) ? (K == 1) : (count_q == CW'(K-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = last_beat ? IDLE : ACCUM;
  end

  always_comb begin
    bus.busy = (state_q == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.acc_out   <= '0;
      bus.done      <= 1'b0;
      acc_q         <= '0;
      count_q       <= '0;
      mode_q        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.enable) begin
        bus.a_out     <= bus.a_in;
        bus.b_out     <= bus.b_in;
        bus.out_valid <= bus.in_valid;
      end
      if (accept) begin
        if (state_q == IDLE) mode_q <= bus.signed_mode;
        if (last_beat) begin
          bus.acc_out <= sum;
          bus.done    <= 1'b1;
          acc_q       <= '0;
          count_q     <= '0;
        end else begin
          acc_q   <= sum;
          count_q <= count_q + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe (DW=8, K=4): directed scenarios plus a randomized
// stream compared against a group-level queue model.
module tb_systolic_pe;
  localparam int DW = 8;
  localparam int K  = 4;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_pe_if #(.DW(DW), .K(K)) bus ();

  systolic_pe #(.DW(DW), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_a      = '0;
  logic [DW-1:0] m_b      = '0;
  logic          m_ov     = 1'b0;
  logic [AW-1:0] m_acc    = '0;
  logic          m_done   = 1'b0;
  logic          m_mode   = 1'b0;
  int            m_prods[$];

  task automatic model_update(input logic r, e, v, s, input logic [DW-1:0] a, b);
    int p;
    int sum;
    logic [31:0] sv;
    if (r) begin
      m_a = '0; m_b = '0; m_ov = 1'b0; m_acc = '0; m_done = 1'b0; m_mode = 1'b0;
      m_prods.delete();
    end else begin
      m_done = 1'b0;
      if (e) begin
        m_a = a; m_b = b; m_ov = v;
        if (v) begin
          if (m_prods.size() == 0) m_mode = s;
          p = m_mode ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
          m_prods.push_back(p);
          if (m_prods.size() == K) begin
            sum = 0;
            foreach (m_prods[i]) sum += m_prods[i];
            sv = sum;
            m_acc = sv[AW-1:0];
            m_done = 1'b1;
            m_prods.delete();
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, e, v, s, input logic [DW-1:0] a, b);
    rst = r;
    bus.enable = e; bus.in_valid = v; bus.signed_mode = s;
    bus.a_in = a; bus.b_in = b;
    @(posedge clk);
    model_update(r, e, v, s, a, b);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      total++;
      if ({bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy} !== 37'd0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d: got a=%h b=%h ov=%b acc=%h done=%b busy=%b, want all 0",
                 i, bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_unsigned_basic();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'(3 + i), 8'd2);
      total++;
      if (bus.busy !== (i < 3) || bus.done !== (i == 3)) begin
        bad++;
        $display("FAIL unsigned_ctrl beat=%0d: got busy=%b done=%b, want busy=%b done=%b",
                 i, bus.busy, bus.done, (i < 3), (i == 3));
      end
      total++;
      if (bus.a_out !== 8'(3 + i) || bus.b_out !== 8'd2 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL unsigned_fwd beat=%0d: got a=%h b=%h ov=%b, want a=%h b=02 ov=1",
                 i, bus.a_out, bus.b_out, bus.out_valid, 8'(3 + i));
      end
    end
    total++;
    if (bus.acc_out !== 18'd36) begin
      bad++;
      $display("FAIL unsigned_acc: got %0d want 36", bus.acc_out);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    total++;
    if (bus.done !== 1'b0 || bus.acc_out !== 18'd36 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_hold: got done=%b acc=%0d ov=%b, want done=0 acc=36 ov=0",
               bus.done, bus.acc_out, bus.out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic [6:0] pat;
    pat = 7'b1010011;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, pat[i], 1'b0, 8'd1, 8'd1);
      total++;
      if (bus.out_valid !== pat[i] || bus.done !== (i == 6) || bus.busy !== (i < 6) ||
          bus.acc_out !== ((i == 6) ? 18'd4 : 18'd36)) begin
        bad++;
        $display("FAIL bubbles step=%0d: got ov=%b done=%b busy=%b acc=%0d, want ov=%b done=%b busy=%b acc=%0d",
                 i, bus.out_valid, bus.done, bus.busy, bus.acc_out, pat[i], (i == 6), (i < 6),
                 (i == 6) ? 4 : 36);
      end
    end
  endtask

  task automatic test_signed_extremes();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, (i == 0), 8'h80, 8'h80);
      total++;
      if (bus.done !== (i == 3)) begin
        bad++;
        $display("FAIL signed_done beat=%0d: got %b want %b", i, bus.done, (i == 3));
      end
    end
    total++;
    if (bus.acc_out !== 18'h10000) begin
      bad++;
      $display("FAIL signed_acc: got %h want 10000", bus.acc_out);
    end
    // signed_mode high on later beats must not affect an unsigned group
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, (i != 0), 8'hFF, 8'hFF);
      total++;
      if (bus.done !== (i == 3) || bus.busy !== (i < 3)) begin
        bad++;
        $display("FAIL unsigned_ff_ctrl beat=%0d: got done=%b busy=%b, want done=%b busy=%b",
                 i, bus.done, bus.busy, (i == 3), (i < 3));
      end
    end
    total++;
    if (bus.acc_out !== 18'h3F804) begin
      bad++;
      $display("FAIL unsigned_ff_acc: got %h want 3f804", bus.acc_out);
    end
  endtask

  task automatic test_enable_freeze();
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL freeze_pre: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom_range(2, 255)), 8'($urandom_range(2, 255)));
      total++;
      if ({bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy} !==
          {8'd1, 8'd1, 1'b1, 18'h3F804, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL freeze_hold cyc=%0d: got a=%h b=%h ov=%b acc=%h done=%b busy=%b, want a=01 b=01 ov=1 acc=3f804 done=0 busy=1",
                 i, bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy);
      end
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    total++;
    if (bus.done !== 1'b1 || bus.acc_out !== 18'd4 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL freeze_resume: got done=%b acc=%0d busy=%b, want done=1 acc=4 busy=0",
               bus.done, bus.acc_out, bus.busy);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd9, 8'd9);
    total++;
    if (bus.done !== 1'b0 || bus.acc_out !== 18'd4 || bus.a_out !== 8'd1 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL freeze_done_clear: got done=%b acc=%0d a=%h ov=%b, want done=0 acc=4 a=01 ov=1",
               bus.done, bus.acc_out, bus.a_out, bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int dones;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd3);
      total++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL midrst_pre beat=%0d: got done=%b busy=%b, want done=0 busy=1", i, bus.done, bus.busy);
      end
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd3);
    total++;
    if ({bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy} !== 37'd0) begin
      bad++;
      $display("FAIL midrst_clear: got a=%h b=%h ov=%b acc=%h done=%b busy=%b, want all 0",
               bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy);
    end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, (i < 4), 1'b0, 8'd2, 8'd2);
      if (bus.done === 1'b1) dones++;
      if (i == 3) begin
        total++;
        if (bus.done !== 1'b1 || bus.acc_out !== 18'd16) begin
          bad++;
          $display("FAIL midrst_result: got done=%b acc=%0d, want done=1 acc=16", bus.done, bus.acc_out);
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL midrst_pulses: got %0d done pulses, want 1", dones);
    end
  endtask

  task automatic test_random();
    logic r, e, v, s;
    logic [DW-1:0] a, b;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 9) < 7);
      s = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      cycle(r, e, v, s, a, b);
      total++;
      if ({bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy} !==
          {m_a, m_b, m_ov, m_acc, m_done, (m_prods.size() != 0)}) begin
        bad++;
        $display("FAIL random cyc=%0d: got a=%h b=%h ov=%b acc=%h done=%b busy=%b, want a=%h b=%h ov=%b acc=%h done=%b busy=%b",
                 i, bus.a_out, bus.b_out, bus.out_valid, bus.acc_out, bus.done, bus.busy,
                 m_a, m_b, m_ov, m_acc, m_done, (m_prods.size() != 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.in_valid = 1'b0; bus.signed_mode = 1'b0;
    bus.a_in = '0; bus.b_in = '0;
    test_reset();
    test_unsigned_basic();
    test_bubbles();
    test_signed_extremes();
    test_enable_freeze();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
